// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder sequencer driving one shared external 4-bit adder slice.
// Define NIBBLE_SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_add_ctrl #(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       sl_a,
    output logic [3:0]       sl_b,
    output logic             sl_cin,
    input  logic [3:0]       sl_s,
    input  logic             sl_cout
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4 || NIBBLES != WIDTH / 4) begin : g_bad_width
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state;
    logic [IDXW-1:0]              idx;
    logic                         carry;
    logic [NIBBLES-1:0][3:0]      op_a;
    logic [NIBBLES-1:0][3:0]      op_b;
    logic [NIBBLES-1:0][3:0]      sum_r;
    logic                         accept;
    logic                         last;

    assign sum    = sum_r;
    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (idx == IDXW'(NIBBLES - 1));

    // The slice only sees operand nibbles while an operation is running.
    always_comb begin
        sl_a   = '0;
        sl_b   = '0;
        sl_cin = 1'b0;
        if (state == RUN) begin
            sl_a   = op_a[idx];
            sl_b   = op_b[idx];
            sl_cin = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum_r <= '0;
            cout  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    sum_r[idx] <= sl_s;
                    carry      <= sl_cout;
                    if (last) begin
                        idx   <= '0;
                        cout  <= sl_cout;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
                        // Carry into the MSB differs from carry out of it.
                        ovf   <= op_a[NIBBLES-1][3] ^ op_b[NIBBLES-1][3] ^ sl_s[3] ^ sl_cout;
`endif
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                IDLE, DONE: begin
                    if (accept) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        idx   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that computes WIDTH-bit additions by time-multiplexing one external 4-bit ripple-carry adder slice, one nibble per cycle, least-significant nibble first.
- Holds the operands and the inter-nibble carry, drives the slice inputs, and captures slice outputs into a result register.
- Presents a start/busy/done handshake to the requester; sits between a control FSM or CPU-side register block and the shared adder slice.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise).
- NIBBLES, WIDTH/4, derived; number of slice passes per operation; not to be overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled on rising edge.
- a  in  WIDTH  operand A; latched when start is accepted.
- b  in  WIDTH  operand B; latched when start is accepted.
- cin  in  1  carry-in; latched when start is accepted.
- busy  out  1  high while an operation is in progress (RUN state).
- done  out  1  one-cycle pulse; sum/cout valid from this cycle.
- sum  out  WIDTH  result register.
- cout  out  1  final carry-out register.
- sl_a  out  4  to slice input a.
- sl_b  out  4  to slice input b.
- sl_cin  out  1  to slice carry-in.
- sl_s  in  4  slice sum output.
- sl_cout  in  1  slice carry output.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0; nibble index=0; carry reg=0; operand regs=0.
- States: IDLE, RUN, DONE.
- Start acceptance: start is accepted only in IDLE or DONE. On acceptance: latch a, b, cin (cin into the carry reg); set index=0; next state RUN. A start in RUN is ignored with no side effects.
- RUN, combinational slice drive:
  - sl_a = opA[4*idx+3:4*idx]
  - sl_b = opB[4*idx+3:4*idx]
  - sl_cin = carry reg
- RUN, each rising edge:
  - sum[4*idx+3:4*idx] <= sl_s
  - carry reg <= sl_cout
  - idx <= idx+1
- RUN exit: on the edge where idx == NIBBLES-1, also cout <= sl_cout; next state DONE.
- Outside RUN: sl_a=0, sl_b=0, sl_cin=0.
- DONE: done=1 for exactly one cycle.
  - Without start: next state IDLE.
  - With start: the start is accepted and the next state is RUN. Back-to-back operations cost no idle cycle.
- busy = (state == RUN), registered state decode, glitch-free.
- Latency: with start sampled at edge E0, done is high in the cycle following edge E0+NIBBLES. Throughput is one operation per NIBBLES+1 cycles.
- Result register:
  - sum and cout hold their last values in IDLE/DONE and after done.
  - sum nibbles are overwritten progressively in RUN; sum is not valid while busy=1.
- Arithmetic: sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of the full sum. Overflow wraps with no saturation.
- Inputs a/b/cin may change freely after acceptance without affecting the operation in flight.
- Reset mid-operation: immediate abort to reset values; no done pulse; the next start behaves normally.
- The external slice is purely combinational. This block assumes the slice output settles within one clk period; no slice handshake.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADD_OVF_EN.
- Defined: adds output port ovf (1 bit) giving signed two's-complement overflow.
  - Set on the final RUN edge: ovf <= (opA[WIDTH-1] ^ opB[WIDTH-1] ^ sl_s[3]) ^ sl_cout.
  - Reset value 0; holds with sum.
- Undefined: no ovf port and no related logic.

Test Plan (all scenarios WIDTH=16):
- Basic carry chain: a=0x1234, b=0x0FCD, cin=0, start one cycle -> busy high 4 cycles; done pulses exactly 5 cycles after the start edge; sum=0x2201, cout=0.
- Full propagate: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Busy rejection: start op 0x0001+0x0001; reassert start with a=0xAAAA in 2nd RUN cycle -> ignored; result sum=0x0002; only one done pulse.
- Back-to-back: start asserted in DONE cycle with a=0x00FF, b=0x0001 -> busy rises next cycle with no IDLE gap; second result sum=0x0100, cout=0.
- Reset mid-op: deassert rst_n during 3rd RUN cycle -> busy, done, sum, cout all 0 immediately. After release, a=0x8000 + b=0x8000 -> sum=0x0000, cout=1.
- Overflow (with NIBBLE_SERIAL_ADD_OVF_EN):
  - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
  - 0xFFFF+0x0001 -> ovf=0.
  - Build without the macro -> no ovf port present.
